// File: rtl/i2c_wb_seq.sv
// Wishbone master that drives an i2c_master_top core: programs the prescaler once,
// then turns single-register read/write requests into TXR/CR writes with SR polling.
module i2c_wb_seq #(
    parameter logic [15:0] PRESCALE = 16'h0031,
    parameter int unsigned POLL_MAX = 1024
) (
    input  logic       wb_clk_i,
    input  logic       arst_i,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_status,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    input  logic       wb_ack_i,
    output logic [3:0] dbg_state
);

    // Handshake: a request transfers on the rising clock edge where req_valid && req_ready;
    // rsp_valid is a single-cycle strobe and needs no ready from the requester.

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

    localparam int SR_RXACK = 7;
    localparam int SR_BUSY  = 6;
    localparam int SR_AL    = 5;
    localparam int SR_TIP   = 1;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_NACK    = 2'd1;
    localparam logic [1:0] ST_ARBLOST = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    typedef enum logic [3:0] {
        INIT_PLO,
        INIT_PHI,
        INIT_CTR,
        IDLE,
        TX_WR,
        CR_WR,
        SR_RD,
        STOP_WR,
        BUSY_RD,
        RX_RD
    } state_t;

    state_t        state, state_d;
    logic          active, active_d;
    logic [1:0]    step, step_d;
    logic [PW-1:0] poll_cnt, poll_d;
    logic          rsp_valid_d;
    logic [7:0]    rsp_rdata_d;
    logic [1:0]    rsp_status_d;
    logic          accept;

    logic          lat_rw;
    logic [6:0]    lat_dev;
    logic [7:0]    lat_reg;
    logic [7:0]    lat_wdata;
    logic [7:0]    tx_byte;
    logic [7:0]    cr_byte;

    assign dbg_state = state;
    assign req_ready = (state == IDLE) && !rsp_valid;

    // Step 2 is the data byte for writes and the repeated-start address for reads;
    // step 3 exists only for reads and carries no TXR byte.
    always_comb begin
        tx_byte = 8'h00;
        cr_byte = 8'h00;
        case (step)
            2'd0: begin tx_byte = {lat_dev, 1'b0}; cr_byte = 8'h90; end
            2'd1: begin tx_byte = lat_reg;         cr_byte = 8'h10; end
            2'd2: begin
                tx_byte = lat_rw ? {lat_dev, 1'b1} : lat_wdata;
                cr_byte = lat_rw ? 8'h90 : 8'h50;
            end
            default: begin tx_byte = 8'h00; cr_byte = 8'h68; end
        endcase
    end

    // An access is two phases: active=0 is the mandatory idle cycle, active=1 holds cyc/stb until ack.
    always_comb begin
        wb_cyc_o = active;
        wb_stb_o = active;
        wb_adr_o = 3'd0;
        wb_dat_o = 8'h00;
        wb_we_o  = 1'b0;
        if (active) begin
            case (state)
                INIT_PLO: begin wb_adr_o = 3'd0; wb_dat_o = PRESCALE[7:0];  wb_we_o = 1'b1; end
                INIT_PHI: begin wb_adr_o = 3'd1; wb_dat_o = PRESCALE[15:8]; wb_we_o = 1'b1; end
                INIT_CTR: begin wb_adr_o = 3'd2; wb_dat_o = 8'h80;          wb_we_o = 1'b1; end
                TX_WR:    begin wb_adr_o = 3'd3; wb_dat_o = tx_byte;        wb_we_o = 1'b1; end
                CR_WR:    begin wb_adr_o = 3'd4; wb_dat_o = cr_byte;        wb_we_o = 1'b1; end
                STOP_WR:  begin wb_adr_o = 3'd4; wb_dat_o = 8'h40;          wb_we_o = 1'b1; end
                SR_RD, BUSY_RD: wb_adr_o = 3'd4;
                RX_RD:    wb_adr_o = 3'd3;
                default:  wb_adr_o = 3'd0;
            endcase
        end
    end

    always_comb begin
        state_d      = state;
        active_d     = active;
        step_d       = step;
        poll_d       = poll_cnt;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = 8'h00;
        rsp_status_d = 2'd0;
        accept       = 1'b0;
        if (state == IDLE) begin
            if (req_valid && req_ready) begin
                accept  = 1'b1;
                step_d  = 2'd0;
                state_d = TX_WR;
            end
        end else if (!active) begin
            active_d = 1'b1;
        end else if (wb_ack_i) begin
            active_d = 1'b0;
            case (state)
                INIT_PLO: state_d = INIT_PHI;
                INIT_PHI: state_d = INIT_CTR;
                INIT_CTR: state_d = IDLE;
                TX_WR:    state_d = CR_WR;
                CR_WR:    begin poll_d = '0; state_d = SR_RD; end
                STOP_WR:  begin poll_d = '0; state_d = BUSY_RD; end
                SR_RD: begin
                    if (wb_dat_i[SR_TIP]) begin
                        if (poll_cnt == POLL_LAST) begin
                            state_d = IDLE; rsp_valid_d = 1'b1; rsp_status_d = ST_TIMEOUT;
                        end else begin
                            poll_d = poll_cnt + PW'(1);
                        end
                    end else if (wb_dat_i[SR_AL]) begin
                        state_d = IDLE; rsp_valid_d = 1'b1; rsp_status_d = ST_ARBLOST;
                    end else if (step == 2'd3) begin
                        state_d = RX_RD;
                    end else if (wb_dat_i[SR_RXACK]) begin
                        state_d = STOP_WR;
                    end else if (!lat_rw && step == 2'd2) begin
                        state_d = IDLE; rsp_valid_d = 1'b1; rsp_status_d = ST_OK;
                    end else begin
                        step_d  = step + 2'd1;
                        state_d = (lat_rw && step == 2'd2) ? CR_WR : TX_WR;
                    end
                end
                BUSY_RD: begin
                    if (!wb_dat_i[SR_BUSY]) begin
                        state_d = IDLE; rsp_valid_d = 1'b1; rsp_status_d = ST_NACK;
                    end else if (poll_cnt == POLL_LAST) begin
                        state_d = IDLE; rsp_valid_d = 1'b1; rsp_status_d = ST_TIMEOUT;
                    end else begin
                        poll_d = poll_cnt + PW'(1);
                    end
                end
                RX_RD: begin
                    state_d = IDLE; rsp_valid_d = 1'b1; rsp_status_d = ST_OK; rsp_rdata_d = wb_dat_i;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state      <= INIT_PLO;
            active     <= 1'b0;
            step       <= 2'd0;
            poll_cnt   <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 8'h00;
            rsp_status <= 2'd0;
        end else begin
            state      <= state_d;
            active     <= active_d;
            step       <= step_d;
            poll_cnt   <= poll_d;
            rsp_valid  <= rsp_valid_d;
            rsp_rdata  <= rsp_rdata_d;
            rsp_status <= rsp_status_d;
        end
    end

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            lat_rw    <= 1'b0;
            lat_dev   <= 7'h00;
            lat_reg   <= 8'h00;
            lat_wdata <= 8'h00;
        end else if (accept) begin
            lat_rw    <= req_rw;
            lat_dev   <= req_dev;
            lat_reg   <= req_reg;
            lat_wdata <= req_wdata;
        end
    end

endmodule

// File: tb/tb_i2c_wb_seq.sv
// Bench for i2c_wb_seq: register-level model of the I2C core plus one slave at address 0x02,
// with scoreboards for core register writes and for responses.
module tb_i2c_wb_seq;

    localparam logic [6:0] SLV = 7'h02;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [6:0] req_dev = 7'h00;
    logic [7:0] req_reg = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_status;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i = 8'h00;
    logic       wb_we_o;
    logic       wb_stb_o;
    logic       wb_cyc_o;
    logic       wb_ack_i = 1'b0;
    logic [3:0] dbg_state;

    always #5 clk = ~clk;

    i2c_wb_seq #(.PRESCALE(16'h0031), .POLL_MAX(4)) dut (
        .wb_clk_i(clk), .arst_i(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_ack_i(wb_ack_i), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_wr_q[$];
    logic [9:0]  exp_rsp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [2:0] adr, input logic [7:0] dat);
        exp_wr_q.push_back({adr, dat});
    endtask

    // ---------------- core + slave model ----------------
    logic [7:0] mem[256];
    logic [7:0] txr = 8'h00, rxr = 8'h00, ptr = 8'h00;
    logic addressed = 1'b0, got_reg = 1'b0, rxack = 1'b0, busy_flag = 1'b0;
    logic force_tip = 1'b0, force_al = 1'b0, hold_ack = 1'b0;
    int tip_left = 0, stop_left = 0, sr_reads = 0;

    task automatic core_cmd(input logic [7:0] cr);
        sr_reads = 0;
        if (cr[7]) busy_flag = 1'b1;
        if (cr[4]) begin
            if (cr[7]) begin
                addressed = (txr[7:1] == SLV);
                got_reg = 1'b0;
                rxack = ~addressed;
            end else if (!addressed) begin
                rxack = 1'b1;
            end else if (!got_reg) begin
                ptr = txr; got_reg = 1'b1; rxack = 1'b0;
            end else begin
                mem[ptr] = txr; ptr = ptr + 8'd1; rxack = 1'b0;
            end
        end
        if (cr[5]) begin
            rxr = mem[ptr]; ptr = ptr + 8'd1;
        end
        tip_left = (cr[4] || cr[5]) ? 2 : 0;
        if (cr[6]) stop_left = 2;
    endtask

    task automatic sr_read(output logic [7:0] v);
        v = {rxack, busy_flag, force_al, 3'b000, (force_tip || tip_left > 0), 1'b0};
        sr_reads++;
        if (tip_left > 0) tip_left--;
        if (stop_left > 0) begin
            stop_left--;
            if (stop_left == 0) busy_flag = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] v;
        if (wb_cyc_o && wb_stb_o && !wb_ack_i && !hold_ack) begin
            wb_ack_i = 1'b1;
            if (wb_we_o) begin
                if (exp_wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_wr_unexpected: got %0h expected none", {wb_adr_o, wb_dat_o});
                end else begin
                    check("bus_wr", {21'd0, wb_adr_o, wb_dat_o}, {21'd0, exp_wr_q.pop_front()});
                end
                if (wb_adr_o == 3'd3) txr = wb_dat_o;
                else if (wb_adr_o == 3'd4) core_cmd(wb_dat_o);
            end else if (wb_adr_o == 3'd4) begin
                sr_read(v);
                wb_dat_i = v;
            end else if (wb_adr_o == 3'd3) begin
                wb_dat_i = rxr;
            end else begin
                wb_dat_i = 8'h00;
            end
        end else begin
            wb_ack_i = 1'b0;
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_rsp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_unexpected: got %0h expected none", {rsp_status, rsp_rdata});
            end else begin
                check("rsp", {22'd0, rsp_status, rsp_rdata}, {22'd0, exp_rsp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        check({name, "_ready"}, {31'd0, req_ready}, 32'd1);
        check({name, "_wr_q_drained"}, exp_wr_q.size(), 32'd0);
    endtask

    task automatic send(input logic rw, input logic [6:0] dev, input logic [7:0] r, input logic [7:0] wd);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_rw = rw; req_dev = dev; req_reg = r; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
        check({name, "_rsp_seen"}, {31'd0, rsp_valid}, 32'd1);
        check({name, "_ready_during_rsp"}, {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check({name, "_ready_after_rsp"}, {31'd0, req_ready}, 32'd1);
        check({name, "_wr_q_drained"}, exp_wr_q.size(), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // reset state and init sequence
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {6'd0, req_ready, rsp_valid, rsp_rdata, rsp_status, wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o},
              32'd0);
        push_wr(3'd0, 8'h31); push_wr(3'd1, 8'h00); push_wr(3'd2, 8'h80);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_low_during_init", {31'd0, req_ready}, 32'd0);
        wait_ready("init");

        // write 0xA5 to reg 5 of slave 0x02
        push_wr(3'd3, 8'h04); push_wr(3'd4, 8'h90);
        push_wr(3'd3, 8'h05); push_wr(3'd4, 8'h10);
        push_wr(3'd3, 8'hA5); push_wr(3'd4, 8'h50);
        exp_rsp_q.push_back({2'd0, 8'h00});
        send(1'b0, SLV, 8'h05, 8'hA5);
        wait_rsp("write");
        check("slave_reg5", {24'd0, mem[5]}, 32'h0000_00A5);

        // read it back through a repeated start
        push_wr(3'd3, 8'h04); push_wr(3'd4, 8'h90);
        push_wr(3'd3, 8'h05); push_wr(3'd4, 8'h10);
        push_wr(3'd3, 8'h05); push_wr(3'd4, 8'h90);
        push_wr(3'd4, 8'h68);
        exp_rsp_q.push_back({2'd0, 8'hA5});
        send(1'b1, SLV, 8'h05, 8'h00);
        wait_rsp("read");

        // absent device: NACK on address, STOP, Busy poll
        push_wr(3'd3, 8'hAA); push_wr(3'd4, 8'h90); push_wr(3'd4, 8'h40);
        exp_rsp_q.push_back({2'd1, 8'h00});
        send(1'b0, 7'h55, 8'h01, 8'h22);
        wait_rsp("nack");

        // TIP stuck: POLL_MAX SR reads then timeout, no STOP
        force_tip = 1'b1;
        push_wr(3'd3, 8'h04); push_wr(3'd4, 8'h90);
        exp_rsp_q.push_back({2'd3, 8'h00});
        send(1'b0, SLV, 8'h06, 8'h11);
        wait_rsp("timeout");
        check("timeout_sr_reads", sr_reads, 32'd4);
        force_tip = 1'b0;

        // arbitration lost: abort, no STOP
        force_al = 1'b1;
        push_wr(3'd3, 8'h04); push_wr(3'd4, 8'h90);
        exp_rsp_q.push_back({2'd2, 8'h00});
        send(1'b0, SLV, 8'h07, 8'h33);
        wait_rsp("arblost");
        force_al = 1'b0;
        repeat (5) @(negedge clk);
        check("arblost_no_stop", exp_wr_q.size(), 32'd0);

        // reset while a stalled access holds stb
        hold_ack = 1'b1;
        send(1'b0, SLV, 8'h07, 8'h44);
        for (int n = 0; n < 50 && !wb_stb_o; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("stall_holds_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
        #2 rst_n = 1'b0;
        #1 check("async_drop_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        hold_ack = 1'b0;
        repeat (2) @(negedge clk);
        push_wr(3'd0, 8'h31); push_wr(3'd1, 8'h00); push_wr(3'd2, 8'h80);
        rst_n = 1'b1;
        @(negedge clk);
        wait_ready("reinit");
        check("reg7_untouched", {24'd0, mem[7]}, 32'd0);

        // read after re-init
        push_wr(3'd3, 8'h04); push_wr(3'd4, 8'h90);
        push_wr(3'd3, 8'h05); push_wr(3'd4, 8'h10);
        push_wr(3'd3, 8'h05); push_wr(3'd4, 8'h90);
        push_wr(3'd4, 8'h68);
        exp_rsp_q.push_back({2'd0, 8'hA5});
        send(1'b1, SLV, 8'h05, 8'h00);
        wait_rsp("read2");

        repeat (3) @(negedge clk);
        check("rsp_q_drained", exp_rsp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
